// File: rtl/data_memory_responder.sv
// Data-memory responder: captures one load/store request, waits WAIT_STATES cycles,
// accesses a byte-lane RAM, then pulses memReady and holds off until the request drops.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dMemRead,
    input  logic        dMemWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic [2:0]  funct3,
    output logic [31:0] readData,
    output logic        memReady,
    output logic        memError
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_rd;
    logic        r_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_f3;

    logic          w_req;
    logic          w_rd;
    logic          w_wr;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [2:0]    w_f3;
    logic          w_go_resp;
    logic          w_f3_ok;
    logic          w_fault;
    logic          w_commit;
    logic [3:0]    w_be;
    logic [31:0]   w_lanes;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic [AW-1:0] w_idx;

    // In IDLE the live inputs are used so a zero-wait access can commit on its capture edge.
    always_comb begin
        w_req = dMemRead | dMemWrite;
        if (r_state == S_IDLE) begin
            w_rd    = dMemRead;
            w_wr    = dMemWrite;
            w_addr  = address;
            w_wdata = writeData;
            w_f3    = funct3;
        end else begin
            w_rd    = r_rd;
            w_wr    = r_wr;
            w_addr  = r_addr;
            w_wdata = r_wdata;
            w_f3    = r_f3;
        end
        w_go_resp = ((r_state == S_IDLE) && w_req && (WAIT_STATES == 0)) ||
                    ((r_state == S_WAIT) && (r_cnt == 4'd0));
        w_idx = w_addr[AW+1:2];

        case (w_f3)
            3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
            3'b100, 3'b101:         w_f3_ok = ~w_wr;
            default:                w_f3_ok = 1'b0;
        endcase
        w_fault = (w_rd & w_wr) | ~w_f3_ok |
                  ((w_f3[1:0] == 2'b01) & w_addr[0]) |
                  ((w_f3[1:0] == 2'b10) & (w_addr[1:0] != 2'b00)) |
                  ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
        w_commit = rst & w_go_resp & w_wr & ~w_fault;

        case (w_f3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_addr[1:0];
                w_lanes = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{w_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_lanes = w_wdata;
            end
        endcase

        w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
        w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];
        case (w_f3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = w_word;
        endcase
    end

    // One RAM per byte lane so partial stores touch only their own lanes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        always_ff @(posedge clk) begin
            if (w_commit && w_be[gi]) begin
                r_mem[w_idx] <= w_lanes[8*gi +: 8];
            end
        end
        assign w_word[8*gi +: 8] = r_mem[w_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_f3     <= 3'd0;
            readData <= 32'd0;
            memReady <= 1'b0;
            memError <= 1'b0;
        end else begin
            memReady <= 1'b0;
            memError <= 1'b0;
            if (w_go_resp) begin
                if (w_fault) begin
                    readData <= 32'd0;
                end else if (w_rd) begin
                    readData <= w_load;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_rd    <= dMemRead;
                        r_wr    <= dMemWrite;
                        r_addr  <= address;
                        r_wdata <= writeData;
                        r_f3    <= funct3;
                        if (WAIT_STATES == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    memReady <= 1'b1;
                    memError <= w_fault;
                    r_state  <= S_HOLD;
                end
                default: begin
                    // A request still held high after its response must not run again.
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed scenarios plus randomized accesses
// checked against a byte-array memory model.
module tb_data_memory_responder;
    localparam int DEPTH = 1024;
    localparam int WS    = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        dMemRead;
    logic        dMemWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [2:0]  funct3;
    logic [31:0] readData;
    logic        memReady;
    logic        memError;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  mem_b [256];
    logic [31:0] exp_rd = 32'd0;

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .dMemRead(dMemRead), .dMemWrite(dMemWrite),
        .address(address), .writeData(writeData), .funct3(funct3),
        .readData(readData), .memReady(memReady), .memError(memError)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_fault(input bit rd, input bit wr, input logic [31:0] a,
                                       input logic [2:0] f3);
        bit legal;
        if (rd && wr) return 1'b1;
        legal = wr ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                   : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) return 1'b1;
        if ((a % size_of(f3)) != 0) return 1'b1;
        if ((a >> 2) >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        int n = size_of(f3);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mem_b[int'(a) + i]) << (8 * i));
        if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [2:0] f3,
                             input bit rel, input string tag);
        bit          flt;
        logic [31:0] expv;
        int          k;
        flt  = model_fault(rd, wr, a, f3);
        expv = flt ? 32'd0 : (rd ? model_load(a, f3) : exp_rd);
        @(negedge clk);
        dMemRead  = rd;
        dMemWrite = wr;
        address   = a;
        writeData = wd;
        funct3    = f3;
        @(posedge clk);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (memReady) begin
                k = i;
                break;
            end
        end
        check({tag, " latency"}, 32'(k), 32'(WS + 1));
        check({tag, " err"}, {31'd0, memError}, {31'd0, flt});
        check({tag, " data"}, readData, expv);
        $display("txn %-12s rd=%0b wr=%0b addr=0x%08h f3=%03b wdata=0x%08h rdata=0x%08h err=%0b",
                 tag, rd, wr, a, f3, wd, readData, memError);
        if (!flt && wr) begin
            for (int i = 0; i < size_of(f3); i++) mem_b[int'(a) + i] = wd[8*i +: 8];
        end
        exp_rd = expv;
        if (rel) begin
            dMemRead  = 1'b0;
            dMemWrite = 1'b0;
            @(posedge clk);
        end
    endtask

    initial begin
        logic [2:0] f3_tab [10];
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};

        // Reset held with a pending request; the first capture follows release.
        rst       = 1'b0;
        dMemRead  = 1'b1;
        dMemWrite = 1'b0;
        address   = 32'(4 * DEPTH);
        writeData = 32'd0;
        funct3    = 3'b010;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("reset ready", {31'd0, memReady}, 32'd0);
            check("reset data", readData, 32'd0);
        end
        rst = 1'b1;
        do_access(1, 0, 32'(4 * DEPTH), 0, 3'b010, 1, "range rst");

        for (int w = 0; w < 64; w++)
            do_access(0, 1, 32'(4 * w), $urandom, 3'b010, 1, "init SW");

        do_access(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 1, "SW 10");
        do_access(1, 0, 32'h10, 0, 3'b010, 1, "LW 10");
        check("LW10 const", readData, 32'hDEADBEEF);
        do_access(0, 1, 32'h12, 32'h0000007F, 3'b000, 1, "SB 12");
        check("SB keeps rdata", readData, 32'hDEADBEEF);
        do_access(1, 0, 32'h12, 0, 3'b000, 1, "LB 12");
        check("LB12 const", readData, 32'h0000007F);
        do_access(1, 0, 32'h10, 0, 3'b010, 1, "LW 10b");
        check("LW10b const", readData, 32'hDE7FBEEF);
        do_access(1, 0, 32'h13, 0, 3'b000, 1, "LB 13");
        check("LB13 const", readData, 32'hFFFFFFDE);
        do_access(1, 0, 32'h13, 0, 3'b100, 1, "LBU 13");
        check("LBU13 const", readData, 32'h000000DE);
        do_access(1, 0, 32'h12, 0, 3'b001, 1, "LH 12");
        check("LH12 const", readData, 32'hFFFFDE7F);
        do_access(1, 0, 32'h12, 0, 3'b101, 1, "LHU 12");
        check("LHU12 const", readData, 32'h0000DE7F);

        do_access(1, 0, 32'h11, 0, 3'b010, 1, "LW 11 mis");
        do_access(0, 1, 32'h11, 32'h0000AAAA, 3'b001, 1, "SH 11 mis");
        do_access(1, 0, 32'h10, 0, 3'b010, 1, "LW 10c");
        check("LW10c const", readData, 32'hDE7FBEEF);
        do_access(1, 0, 32'h10, 0, 3'b011, 1, "f3 011");
        do_access(1, 1, 32'h10, 0, 3'b010, 1, "rd+wr");
        do_access(1, 0, 32'(4 * DEPTH), 0, 3'b010, 1, "range");

        // Request held long after the response: no second pulse.
        do_access(1, 0, 32'h10, 0, 3'b010, 0, "hold LW");
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("hold no pulse", {31'd0, memReady}, 32'd0);
        end
        dMemRead = 1'b0;
        @(posedge clk);
        do_access(1, 0, 32'h13, 0, 3'b100, 1, "after hold");

        // Reset lands on the commit edge of a store.
        @(negedge clk);
        dMemWrite = 1'b1;
        address   = 32'h20;
        writeData = 32'h12345678;
        funct3    = 3'b010;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst store ready", {31'd0, memReady}, 32'd0);
        check("rst store data", readData, 32'd0);
        rst       = 1'b1;
        dMemWrite = 1'b0;
        exp_rd    = 32'd0;
        @(posedge clk);
        #1;
        check("rst store idle", {31'd0, memReady}, 32'd0);
        do_access(1, 0, 32'h20, 0, 3'b010, 1, "LW 20");

        for (int t = 0; t < 60; t++) begin
            bit          rd;
            bit          wr;
            logic [2:0]  f3;
            logic [31:0] a;
            int          r;
            r  = int'($urandom_range(0, 19));
            rd = (r < 11) || (r == 19);
            wr = (r >= 11);
            f3 = f3_tab[$urandom_range(0, 9)];
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) a = a & ~32'(size_of(f3) - 1);
            if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 31));
            do_access(rd, wr, a, $urandom, f3, 1, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Responder side of the core's data-memory interface: accepts load/store requests issued by the multicycle control unit (`dMemRead`/`dMemWrite`, byte address, RV32I `funct3`), performs the access on an internal word-organised RAM with a configurable number of wait states, and returns a one-cycle `memReady` completion pulse. It handles byte/halfword/word lane selection, load sign/zero extension, and misalignment and range errors. It sits beside `instructionMemory` in the processor wrapper, driven by the ALU result (address) and the rs2 operand (store data).

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two, 16..65536.
- `WAIT_STATES`, 1: extra cycles between request capture and response; legal range 0..15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `dMemRead`  in  1  load request; held high by the requester until `memReady`.
- `dMemWrite`  in  1  store request; same holding rule.
- `address`  in  32  byte address.
- `writeData`  in  32  store data; the low byte/half is used for SB/SH.
- `funct3`  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `readData`  out  32  load result, registered; valid while `memReady`=1 and held until the next response.
- `memReady`  out  1  one-cycle completion pulse.
- `memError`  out  1  asserted only together with `memReady`, for a faulted access.

## Operation
- FSM states: IDLE, WAIT, RESP, HOLD.
- IDLE: when `dMemRead|dMemWrite` is sampled high, capture `address`, `writeData`, `funct3` and the op. Go to WAIT if `WAIT_STATES`>0, otherwise go to RESP.
- WAIT: a down-counter is loaded with `WAIT_STATES`-1 at capture. It decrements each cycle and leaves for RESP when it reaches 0. Request inputs are ignored in WAIT.
- RESP: `memReady`=1 for one cycle. Next state is HOLD.
- HOLD: wait until both request inputs are low, then return to IDLE. This prevents a held request from executing twice.
- Fault on any of the following:
  - both `dMemRead` and `dMemWrite` high at capture;
  - `funct3` not in {000,001,010,100,101}, or a store using 100/101;
  - H/HU/SH with `address[0]`=1;
  - W/SW with `address[1:0]`≠0;
  - word index `address[31:2]` ≥ `DEPTH_WORDS`.
- On fault: `memError`=1, `readData`=0, no RAM write.
- Loads are little-endian.
  - B/BU: byte at lane `address[1:0]`.
  - H/HU: half at `address[1]`.
  - B/H are sign-extended from bit 7/15. BU/HU are zero-extended.
- Stores use byte enables derived from `funct3` and `address[1:0]`. Only the enabled lanes change; the others keep their old contents.
- RAM contents are not reset.

## Timing
- Reset values: state=IDLE, `memReady`=0, `memError`=0, `readData`=0, counter=0.
- Request sampled at edge E → `memReady` high in the cycle after edge E+1+`WAIT_STATES`. This is 1 cycle at `WAIT_STATES`=0 and 2 cycles at the default.
- A store commits at the same edge that enters RESP.
- `readData` updates at that edge. Stores leave `readData` unchanged.
- Minimum spacing between accepted requests: the response cycle plus one low cycle in HOLD. Back-to-back throughput is therefore one access per `WAIT_STATES`+3 cycles.
- Reset asserted mid-access (WAIT or RESP): return to IDLE at that edge and clear the outputs.
  - A store whose commit edge coincides with reset is not written.
  - Commits already taken are kept.
- Requests that change while in WAIT/RESP/HOLD are ignored; the captured values are authoritative.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `dMemRead`=1 → `memReady`=0, `readData`=0 throughout; first capture occurs at the first edge with `rst`=1.
- SW 0xDEADBEEF to 0x10, then LW 0x10 with `WAIT_STATES`=1 → `readData`=0xDEADBEEF, `memReady` pulses exactly 2 cycles after each capture, `memError`=0.
- After the above, SB 0x7F to 0x12, then LB 0x12 → 0x0000007F. LW 0x10 → 0xDE7FBEEF. LB 0x13 → 0xFFFFFFDE. LBU 0x13 → 0x000000DE. LH 0x12 → 0xFFFFDE7F. LHU 0x12 → 0x0000DE7F.
- Faults:
  - LW 0x11 → `memError`=1, `readData`=0.
  - SH 0x11 → `memError`=1; a following LW 0x10 is unchanged.
  - `funct3`=011 → error.
  - `dMemRead`=`dMemWrite`=1 → error.
  - Address 4·`DEPTH_WORDS` → error.
- Hold: keep `dMemRead`=1 for 6 cycles after `memReady` → exactly one `memReady` pulse; the next access starts only after the request drops for 1 cycle.
- Reset mid-store: SW 0x12345678 to 0x20, assert `rst`=0 on the commit edge → a later LW 0x20 returns the prior contents, and the FSM returns to IDLE.
